wb_fb_fetch: RTL
================

WB_FB_FETCH -- requirements
Module: wb_fb_fetch

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 8, words per wishbone burst (power of two, 2..2**(FIFO_ADDR_BITS-1)).
REQ-002 SHALL provide parameter FIFO_ADDR_BITS, default 4, log2 of internal FIFO depth (default depth 16 words).
REQ-003 SHALL have ports (single clock; reset asynchronous, active-high):
- clk  in  1  main clock, also the wishbone clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle fetch request.
- base_addr  in  30 [31:2]  first word address, sampled on accepted start.
- word_cnt  in  16  words to fetch, sampled on accepted start.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the fetch completes.
- pop  in  1  consumer removes the head word.
- data_o  out  32  FIFO head word (first-word-fall-through).
- empty  out  1  FIFO empty.
- underflow  out  1  sticky pop-while-empty flag (see REQ-024).
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  wishbone master controls.
- wbm_addr_o  out  30 [31:2]  word address.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type, constant 2'b00.
- wbm_sel_o  out  4  byte select, constant 4'hF.
- wbm_data_i  in  32  read data.
- wbm_ack_i  in  1  wishbone acknowledge.

Function
REQ-004 SHALL be a read-only master: wbm_we_o is constant 0.
REQ-005 SHALL implement states IDLE, WAIT, BURST.
REQ-006 IDLE: start=1 SHALL latch base_addr/word_cnt into addr/remaining and enter WAIT; busy=1 from the next cycle.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 WAIT: remaining=0 SHALL pulse done for one cycle, clear busy and return to IDLE in the same cycle; word_cnt=0 therefore gives done two cycles after start.
REQ-009 WAIT: burst length L = min(BURST_LEN, remaining); FIFO free entries >= L SHALL enter BURST with cyc=stb=1 on the next cycle.
REQ-010 FIFO free entries SHALL not be reserved in WAIT; the check uses the current occupancy.
REQ-011 BURST: wbm_cti_o SHALL be 3'b010 on all beats except the last beat of the burst, which uses 3'b111; L=1 uses 3'b111 only.
REQ-012 Each cycle with wbm_ack_i=1 in BURST SHALL push wbm_data_i into the FIFO, increment addr by 1 and decrement remaining and the beat counter by 1.
REQ-013 wbm_addr_o SHALL always equal the address of the current beat; addr SHALL wrap from 30'h3FFFFFFF to 0.
REQ-014 On the ack of the last beat, cyc/stb SHALL deassert on the next cycle and the FSM enters WAIT.
REQ-015 wbm_ack_i outside BURST SHALL be ignored (no push).
REQ-016 Wait states (stb=1, ack=0) SHALL hold all wishbone outputs stable.
REQ-017 FIFO: pop with empty=0 SHALL advance the head; push and pop in the same cycle SHALL keep the occupancy unchanged.
REQ-018 FIFO overflow SHALL be impossible by construction (REQ-009).
REQ-019 pop with empty=1 SHALL leave the FIFO unchanged.
REQ-020 FIFO contents SHALL be retained across fetches; start does not flush them.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, done=0, cyc=stb=0, wbm_cti_o=3'b000, wbm_addr_o=0, FIFO empty (empty=1), underflow=0.
REQ-022 rst asserted mid-burst SHALL drop cyc/stb without completing the burst; the next start begins a new fetch.
REQ-023 data_o value during and after reset is don't-care while empty=1.

Configuration
REQ-024 Macro FB_FETCH_UNDERFLOW_EN defined: underflow SHALL set on pop with empty=1 and stay set until rst. Undefined: underflow SHALL be constant 0 and no flag register is built.

Verification
REQ-025 start, base_addr=0x100, word_cnt=16, zero-wait acks, pop every cycle -> two bursts at 0x100..0x107 and 0x108..0x10F, cti 010x7 then 111 each, done once, data in order.
REQ-026 word_cnt=3 -> one burst of 3 beats, cti 010,010,111; done; empty=0 with 3 words queued.
REQ-027 word_cnt=20, no pops -> 16 words fetched, FSM stalls in WAIT; popping 4 words -> final 4-beat burst, then done.
REQ-028 base_addr=30'h3FFFFFFE, word_cnt=4 -> addresses 3FFFFFFE, 3FFFFFFF, 0, 1.
REQ-029 rst pulse at beat 3 of 8 -> cyc=0 immediately, empty=1, busy=0; a following start fetches normally.
REQ-030 pop with empty=1, FB_FETCH_UNDERFLOW_EN defined -> underflow=1 sticky; undefined -> underflow=0.

Source files
------------

// File: rtl/wb_fb_fetch.sv
// Wishbone burst read master feeding a first-word-fall-through FIFO.
// Optional sticky pop-while-empty flag: define FB_FETCH_UNDERFLOW_EN.
module wb_fb_fetch #(
  parameter int BURST_LEN      = 8,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] base_addr,
  input  logic [15:0] word_cnt,
  output logic        busy,
  output logic        done,
  input  logic        pop,
  output logic [31:0] data_o,
  output logic        empty,
  output logic        underflow,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [29:0] wbm_addr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                    r_state;
  logic [29:0]               r_addr;
  logic [15:0]               r_rem;
  logic [15:0]               r_beat;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_cyc;
  logic [2:0]                r_cti;
  logic [31:0]               r_mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] r_wr;
  logic [FIFO_ADDR_BITS-1:0] r_rd;
  logic [FIFO_ADDR_BITS:0]   r_cnt;

  logic                      w_push;
  logic                      w_pop;
  logic [15:0]               w_len;
  logic [FIFO_ADDR_BITS:0]   w_free;
  logic                      w_fits;

  assign w_push = (r_state == S_BURST) && wbm_ack_i;
  assign w_pop  = pop && (r_cnt != '0);
  assign w_len  = (r_rem < 16'(BURST_LEN)) ? r_rem : 16'(BURST_LEN);
  assign w_free = (FIFO_ADDR_BITS+1)'(DEPTH) - r_cnt;
  // Free space is checked against live occupancy; pops during a burst only add room.
  assign w_fits = 16'(w_free) >= w_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= 1'b0;
      r_cti   <= 3'b000;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_addr  <= base_addr;
          r_rem   <= word_cnt;
          r_busy  <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_rem == 16'd0) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else if (w_fits) begin
          r_beat  <= w_len;
          r_cyc   <= 1'b1;
          r_cti   <= (w_len == 16'd1) ? 3'b111 : 3'b010;
          r_state <= S_BURST;
        end
        S_BURST: if (wbm_ack_i) begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
          r_beat <= r_beat - 1'b1;
          if (r_beat == 16'd1) begin
            r_cyc   <= 1'b0;
            r_cti   <= 3'b000;
            r_state <= S_WAIT;
          end else begin
            r_cti <= (r_beat == 16'd2) ? 3'b111 : 3'b010;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wbm_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FB_FETCH_UNDERFLOW_EN
  logic r_unf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_unf <= 1'b0;
    else if (pop && r_cnt == '0)   r_unf <= 1'b1;
  end
  assign underflow = r_unf;
`else
  assign underflow = 1'b0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_o     = r_mem[r_rd];
  assign empty      = (r_cnt == '0);
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_we_o   = 1'b0;
  assign wbm_addr_o = r_addr;
  assign wbm_cti_o  = r_cti;
  assign wbm_bte_o  = 2'b00;
  assign wbm_sel_o  = 4'hF;
endmodule
